// File: rtl/xor_logic_pkg.sv
// Shared types for the pipelined bitwise logic unit.
// Mode encoding matches the in_mode port field.
package xor_logic_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_XOR,
        MODE_AND,
        MODE_OR,
        MODE_ACC
    } mode_t;

endpackage

// File: rtl/xor_logic_unit_if.sv
// Operand/result valid-ready bundle for xor_logic_unit.
// out_parity is present only when PARITY_OUT_EN is defined.
interface xor_logic_unit_if
    import xor_logic_pkg::*;
#(
    parameter int W = 16
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    mode_t        in_mode;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_p;
`ifdef PARITY_OUT_EN
    logic         out_parity;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
        output in_ready, out_valid, out_p, out_parity
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
        input  in_ready, out_valid, out_p, out_parity
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
        output in_ready, out_valid, out_p
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
        input  in_ready, out_valid, out_p
    );
`endif

endinterface

// File: rtl/logic_op_core.sv
// Combinational operator: XOR/AND/OR or running XOR checksum step.
// acc_clr zeroes the checksum base before the new operands fold in.
module logic_op_core
    import xor_logic_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  mode_t        mode_i,
    input  logic [W-1:0] acc_i,
    input  logic         acc_clr_i,
    output logic [W-1:0] r_o,
    output logic [W-1:0] acc_next_o
);

    logic [W-1:0] acc_base;

    assign acc_base   = acc_clr_i ? '0 : acc_i;
    assign acc_next_o = acc_base ^ a_i ^ b_i;

    always_comb begin
        r_o = '0;
        unique case (1'b1)
            (mode_i == MODE_XOR): r_o = a_i ^ b_i;
            (mode_i == MODE_AND): r_o = a_i & b_i;
            (mode_i == MODE_OR):  r_o = a_i | b_i;
            (mode_i == MODE_ACC): r_o = acc_next_o;
            default:              r_o = '0;
        endcase
    end

endmodule

// File: rtl/xor_logic_unit.sv
// Pipelined logic unit: output reg plus 1-entry skid, 1-cycle latency.
// Optional PARITY_OUT_EN adds a stored parity bit per result.
module xor_logic_unit
    import xor_logic_pkg::*;
#(
    parameter int W = 16
) (
    input logic              clk,
    input logic              rst_n,
    xor_logic_unit_if.slave  bus
);

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] out_r_q, out_r_d;
    logic [W-1:0] skid_r_q, skid_r_d;
    logic         out_v_q, out_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] r_new;
    logic [W-1:0] acc_next;
    logic         accept;
    logic         load_out;

    logic_op_core #(.W(W)) u_core (
        .a_i        (bus.in_a),
        .b_i        (bus.in_b),
        .mode_i     (bus.in_mode),
        .acc_i      (acc_q),
        .acc_clr_i  (bus.acc_clr),
        .r_o        (r_new),
        .acc_next_o (acc_next)
    );

    // skid_v_q is a flop, so in_ready has no path from out_ready
    assign accept   = bus.in_valid & ~skid_v_q;
    assign load_out = ~out_v_q | bus.out_ready;

    assign bus.in_ready  = ~skid_v_q;
    assign bus.out_valid = out_v_q;
    assign bus.out_p     = {1'b0, out_r_q};

    always_comb begin
        acc_d    = acc_q;
        out_r_d  = out_r_q;
        out_v_d  = out_v_q;
        skid_r_d = skid_r_q;
        skid_v_d = skid_v_q;
        if (bus.acc_clr)
            acc_d = '0;
        if (accept && bus.in_mode == MODE_ACC)
            acc_d = acc_next;
        if (load_out) begin
            if (skid_v_q) begin
                out_r_d  = skid_r_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                out_r_d = r_new;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_r_d = r_new;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            out_r_q  <= '0;
            out_v_q  <= 1'b0;
            skid_r_q <= '0;
            skid_v_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            out_r_q  <= out_r_d;
            out_v_q  <= out_v_d;
            skid_r_q <= skid_r_d;
            skid_v_q <= skid_v_d;
        end
    end

`ifdef PARITY_OUT_EN
    logic out_par_q, out_par_d;
    logic skid_par_q, skid_par_d;

    assign bus.out_parity = out_par_q;

    // parity travels with its result through the same reg slots
    always_comb begin
        out_par_d  = out_par_q;
        skid_par_d = skid_par_q;
        if (load_out) begin
            if (skid_v_q)
                out_par_d = skid_par_q;
            else if (accept)
                out_par_d = ^r_new;
        end else if (accept) begin
            skid_par_d = ^r_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q  <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            out_par_q  <= out_par_d;
            skid_par_q <= skid_par_d;
        end
    end
`endif

endmodule

// File: tb/tb_xor_logic_unit.sv
// Scoreboard bench for xor_logic_unit: directed cases plus random stream.
// Define PARITY_OUT_EN to also check out_parity.
module tb_xor_logic_unit;
    import xor_logic_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W:0] p;
        logic       par;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xor_logic_unit_if #(.W(W)) bus ();

    xor_logic_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           n_pass = 0;
    int           n_chk  = 0;
    logic [W-1:0] acc_m  = '0;
    int           ready_mode = 0;

    task automatic check(input string name, input logic [W:0] got,
                         input logic [W:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    // reference: result and checksum from the mode rules
    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                                input int m, input bit clr);
        exp_t         e;
        logic [W-1:0] r;
        if (clr) acc_m = '0;
        case (m)
            0: r = a ^ b;
            1: r = a & b;
            2: r = a | b;
            default: begin
                acc_m = acc_m ^ a ^ b;
                r = acc_m;
            end
        endcase
        e.p   = {1'b0, r};
        e.par = ^r;
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int m, input bit clr);
        bit done = 0;
        int cyc = 0;
        bit c = clr;
        while (!done) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = a;
            bus.in_b     = b;
            bus.in_mode  = mode_t'(m[1:0]);
            bus.acc_clr  = c;
            if (bus.in_ready) begin
                model_accept(a, b, m, c);
                done = 1;
            end else begin
                if (c) acc_m = '0;
                cyc++;
                if (cyc > 50) begin
                    fail_now("send_timeout");
                    done = 1;
                end
            end
            c = 0;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((sb.size() != 0 || bus.out_valid) && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (c >= 300) fail_now("drain_timeout");
    endtask

    task automatic check_out(input string name, input logic [W:0] exp);
        check({name, "_valid"}, {{W{1'b0}}, bus.out_valid}, 1);
        check(name, bus.out_p, exp);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // monitor: pop one expected result per output handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                fail_now("sb_unexpected_output");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_out_p", bus.out_p, e.p);
`ifdef PARITY_OUT_EN
                check("sb_parity", {{W{1'b0}}, bus.out_parity}, {{W{1'b0}}, e.par});
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        exp_t ea;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mode   = MODE_XOR;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", {{W{1'b0}}, bus.out_valid}, 0);
        check("rst_in_ready", {{W{1'b0}}, bus.in_ready}, 1);
        check("rst_out_p", bus.out_p, 0);
`ifdef PARITY_OUT_EN
        check("rst_parity", {{W{1'b0}}, bus.out_parity}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        send(16'h00FF, 16'h0F0F, 0, 0);
        check_out("xor", 17'h00FF0);
`ifdef PARITY_OUT_EN
        check("xor_parity", {{W{1'b0}}, bus.out_parity}, 0);
`endif
        send(16'hF0F0, 16'hFF00, 1, 0);
        check_out("and", 17'h0F000);
        send(16'hF0F0, 16'hFF00, 2, 0);
        check_out("or", 17'h0FFF0);
        send(16'h1234, 16'h0000, 3, 0);
        check_out("acc1", 17'h01234);
        send(16'h00FF, 16'hFF00, 3, 0);
        check_out("acc2", 17'h0EDCB);
        send(16'h1234, 16'h0000, 3, 0);
        check_out("acc3", 17'h0FFFF);
        send(16'h0001, 16'h0000, 3, 1);
        check_out("acc_clr", 17'h00001);
        drain();

        // stall: A in output, B in skid, C held off
        ready_mode = 2;
        @(posedge clk);
        #2;
        send(16'hAAAA, 16'h0F0F, 0, 0);
        ea = sb[0];
        send(16'h1111, 16'h2222, 2, 0);
        for (int i = 0; i < 2; i++) begin
            check("stall_in_ready", {{W{1'b0}}, bus.in_ready}, 0);
            check_out("stall_hold", ea.p);
            @(negedge clk);
        end
        fork
            send(16'h5555, 16'h00FF, 1, 0);
            begin
                repeat (3) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain();

        // async reset with output and skid occupied
        ready_mode = 2;
        @(posedge clk);
        #2;
        send(16'h0F00, 16'h0000, 3, 0);
        send(16'h00F0, 16'h0000, 3, 0);
        check("pre_rst_in_ready", {{W{1'b0}}, bus.in_ready}, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {{W{1'b0}}, bus.out_valid}, 0);
        check("mid_rst_in_ready", {{W{1'b0}}, bus.in_ready}, 1);
        sb.delete();
        acc_m = '0;
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0003, 16'h0000, 3, 0);
        check_out("post_rst_acc", 17'h00003);
        drain();

        // random stream with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send(ra, rb, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) @(negedge clk);
        end
        ready_mode = 0;
        drain();
        check("sb_empty", W'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
